multichannel_delay_timer: RTL and testbench

- Array of NCH independent programmable delay timers plus one shared free-running timestamp counter, all on a single clock.
- Host loads each channel's delay word-by-word over a narrow write bus, then triggers it.
- Each channel emits a one-cycle fire pulse after the programmed delay, in one-shot or periodic mode, and captures the timestamp at every fire.
- Sits between the host command decoder and the pulse/measurement sequencers on the memory board.

---
 rtl/multichannel_delay_timer_pkg.sv | 27 ++
 rtl/delay_timer_channel.sv | 80 ++++++++
 rtl/multichannel_delay_timer.sv | 69 ++++++
 tb/tb_multichannel_delay_timer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multichannel_delay_timer_pkg.sv
// Shared widths, channel state encoding and width helper for the multichannel delay timer.
package multichannel_delay_timer_pkg;

   localparam int CNT_W_DEF  = 48;
   localparam int WORD_W_DEF = 16;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_COUNT = 1'b1;

   typedef enum logic {
      S_IDLE  = ST_IDLE,
      S_COUNT = ST_COUNT
   } ch_state_e;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/delay_timer_channel.sv
// One delay channel: word-shifted shadow, down-counter, mode latch, fire-time capture.
// Latency: fire L+1 cycles after the start edge; periodic fires spaced L+1 cycles.
// Backpressure: none; start is ignored while counting and abort always wins.
module delay_timer_channel
   import multichannel_delay_timer_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              start,
   input  logic              periodic,
   input  logic              abort,
   input  logic [CNT_W-1:0]  timestamp,
   output logic              busy,
   output logic              fire,
   output logic [CNT_W-1:0]  fire_ts
);

   logic [CNT_W-1:0] shadow;
   logic [CNT_W-1:0] shadow_nxt;
   logic [CNT_W-1:0] cnt;
   logic             mode;
   ch_state_e        state;

   if (CNT_W > WORD_W) begin : g_shift
      assign shadow_nxt = {shadow[CNT_W-WORD_W-1:0], wr_data};
   end else begin : g_word
      assign shadow_nxt = wr_data;
   end

   // Loads and reloads read the shadow as it stood before this edge's write.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow  <= '0;
         cnt     <= '0;
         mode    <= 1'b0;
         state   <= S_IDLE;
         fire    <= 1'b0;
         fire_ts <= '0;
      end else begin
         fire <= 1'b0;
         if (wr_en) begin
            shadow <= shadow_nxt;
         end
         if (abort) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     cnt   <= shadow;
                     mode  <= periodic;
                     state <= S_COUNT;
                  end
               end
               S_COUNT: begin
                  if (cnt != '0) begin
                     cnt <= cnt - CNT_W'(1);
                  end else begin
                     fire    <= 1'b1;
                     fire_ts <= timestamp;
                     if (mode) begin
                        cnt <= shadow;
                     end else begin
                        state <= S_IDLE;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign busy = (state == S_COUNT);

endmodule

// File: rtl/multichannel_delay_timer.sv
// NCH independent delay channels sharing one free-running timestamp and a capture read mux.
// Latency: per-channel fire L+1 cycles after start; rd_fire_ts is a combinational mux.
// Backpressure: none; writes are always accepted, out-of-range channel writes are dropped.
module multichannel_delay_timer
   import multichannel_delay_timer_pkg::*;
#(
   parameter int NCH    = 4,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int WORD_W = WORD_W_DEF,
   parameter int CH_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [NCH-1:0]    start,
   input  logic [NCH-1:0]    periodic,
   input  logic [NCH-1:0]    abort,
   output logic [NCH-1:0]    busy,
   output logic [NCH-1:0]    fire,
   input  logic              ts_clr,
   output logic [CNT_W-1:0]  timestamp,
   input  logic [CH_W-1:0]   rd_ch,
   output logic [CNT_W-1:0]  rd_fire_ts
);

   logic [CNT_W-1:0] fire_ts [NCH];
   logic [CNT_W-1:0] rd_tab  [2**CH_W];

   always_ff @(posedge clk) begin
      if (rst || ts_clr) begin
         timestamp <= '0;
      end else begin
         timestamp <= timestamp + CNT_W'(1);
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      delay_timer_channel #(
         .CNT_W  (CNT_W),
         .WORD_W (WORD_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .wr_en     (wr_en && (wr_ch == CH_W'(i))),
         .wr_data   (wr_data),
         .start     (start[i]),
         .periodic  (periodic[i]),
         .abort     (abort[i]),
         .timestamp (timestamp),
         .busy      (busy[i]),
         .fire      (fire[i]),
         .fire_ts   (fire_ts[i])
      );
   end

   // Pad the read table to the full index range so unused selects read zero.
   for (genvar i = 0; i < 2**CH_W; i++) begin : g_rd
      if (i < NCH) begin : g_used
         assign rd_tab[i] = fire_ts[i];
      end else begin : g_pad
         assign rd_tab[i] = '0;
      end
   end

   assign rd_fire_ts = rd_tab[rd_ch];

endmodule

// File: tb/tb_multichannel_delay_timer.sv
// Scoreboard bench: directed stimulus queues expected fire events, negedge monitors pop and compare.
module tb_multichannel_delay_timer;

   typedef logic [47:0] w48_t;
   typedef struct {
      w48_t       edge_no;
      logic [3:0] fire;
      logic [3:0] bmask;
      logic [3:0] bexp;
      w48_t       ts;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   w48_t edge_cnt = '0;
   w48_t zero_a;
   w48_t zero_b;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   // Main instance: 4 channels, 48-bit counters, 16-bit words.
   logic        wr_en_a;
   logic [1:0]  wr_ch_a;
   logic [15:0] wr_data_a;
   logic [3:0]  start_a, periodic_a, abort_a, busy_a, fire_a;
   logic        ts_clr_a;
   w48_t        timestamp_a;
   logic [1:0]  rd_ch_a;
   w48_t        rd_fire_ts_a;

   // Reduced instance: 3 channels, 12-bit counters, 4-bit words.
   logic        wr_en_b;
   logic [1:0]  wr_ch_b;
   logic [3:0]  wr_data_b;
   logic [2:0]  start_b, periodic_b, abort_b, busy_b, fire_b;
   logic        ts_clr_b;
   logic [11:0] timestamp_b;
   logic [1:0]  rd_ch_b;
   logic [11:0] rd_fire_ts_b;

   multichannel_delay_timer #(.NCH(4), .CNT_W(48), .WORD_W(16), .CH_W(2)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_ch(wr_ch_a), .wr_data(wr_data_a),
      .start(start_a), .periodic(periodic_a), .abort(abort_a), .busy(busy_a), .fire(fire_a),
      .ts_clr(ts_clr_a), .timestamp(timestamp_a), .rd_ch(rd_ch_a), .rd_fire_ts(rd_fire_ts_a)
   );

   multichannel_delay_timer #(.NCH(3), .CNT_W(12), .WORD_W(4), .CH_W(2)) u_small (
      .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_ch(wr_ch_b), .wr_data(wr_data_b),
      .start(start_b), .periodic(periodic_b), .abort(abort_b), .busy(busy_b), .fire(fire_b),
      .ts_clr(ts_clr_b), .timestamp(timestamp_b), .rd_ch(rd_ch_b), .rd_fire_ts(rd_fire_ts_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 48'd1;

   task automatic check(input string nm, input w48_t act, input w48_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input w48_t ed, input logic [3:0] f, input logic [3:0] bm,
                         input logic [3:0] be, input w48_t ts);
      exp_t e;
      e.edge_no = ed; e.fire = f; e.bmask = bm; e.bexp = be; e.ts = ts;
      q_a.push_back(e);
   endtask

   task automatic push_b(input w48_t ed, input logic [2:0] f, input logic [2:0] bm,
                         input logic [2:0] be, input w48_t ts);
      exp_t e;
      e.edge_no = ed; e.fire = {1'b0, f}; e.bmask = {1'b0, bm}; e.bexp = {1'b0, be}; e.ts = ts;
      q_b.push_back(e);
   endtask

   task automatic load_a(input logic [1:0] ch, input w48_t val);
      w48_t sh;
      sh = val;
      repeat (3) begin
         wr_en_a = 1'b1; wr_ch_a = ch; wr_data_a = sh[47:32];
         tick();
         sh = sh << 16;
      end
      wr_en_a = 1'b0;
   endtask

   task automatic load_b(input logic [1:0] ch, input logic [11:0] val);
      logic [11:0] sh;
      sh = val;
      repeat (3) begin
         wr_en_b = 1'b1; wr_ch_b = ch; wr_data_b = sh[11:8];
         tick();
         sh = sh << 4;
      end
      wr_en_b = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (fire_a != 4'd0) begin
         if (q_a.size() == 0) begin
            check("a_unexpected_fire", 48'(fire_a), 48'd0);
         end else begin
            e = q_a.pop_front();
            check("a_fire_edge", edge_cnt, e.edge_no);
            check("a_fire_mask", 48'(fire_a), 48'(e.fire));
            check("a_busy_at_fire", 48'(busy_a & e.bmask), 48'(e.bexp));
            check("a_capture", rd_fire_ts_a, e.ts);
         end
      end else if (q_a.size() != 0 && q_a[0].edge_no < edge_cnt) begin
         e = q_a.pop_front();
         check("a_missed_fire", 48'(fire_a), 48'(e.fire));
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (fire_b != 3'd0) begin
         if (q_b.size() == 0) begin
            check("b_unexpected_fire", 48'(fire_b), 48'd0);
         end else begin
            e = q_b.pop_front();
            check("b_fire_edge", edge_cnt, e.edge_no);
            check("b_fire_mask", 48'(fire_b), 48'(e.fire));
            check("b_busy_at_fire", 48'(busy_b & e.bmask[2:0]), 48'(e.bexp));
            check("b_capture", 48'(rd_fire_ts_b), e.ts);
         end
      end else if (q_b.size() != 0 && q_b[0].edge_no < edge_cnt) begin
         e = q_b.pop_front();
         check("b_missed_fire", 48'(fire_b), 48'(e.fire));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run still active at time limit, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      w48_t n;
      w48_t cap0;
      int unsigned offs [9] = '{5, 9, 13, 17, 21, 25, 27, 29, 31};

      rst = 1'b1;
      wr_en_a = 1'b0; wr_ch_a = '0; wr_data_a = '0; start_a = '0; periodic_a = '0;
      abort_a = '0; ts_clr_a = 1'b0; rd_ch_a = '0;
      wr_en_b = 1'b0; wr_ch_b = '0; wr_data_b = '0; start_b = '0; periodic_b = '0;
      abort_b = '0; ts_clr_b = 1'b0; rd_ch_b = '0;
      repeat (3) tick();
      zero_a = edge_cnt;
      zero_b = edge_cnt;
      rst = 1'b0;
      check("rst_busy_a", 48'(busy_a), 48'd0);
      check("rst_fire_a", 48'(fire_a), 48'd0);
      check("rst_ts_a", timestamp_a, 48'd0);
      check("rst_cap_a", rd_fire_ts_a, 48'd0);
      check("rst_busy_b", 48'(busy_b), 48'd0);
      check("rst_ts_b", 48'(timestamp_b), 48'd0);

      // One-shot L=5 on ch0
      load_a(2'd0, 48'd5);
      check("ts_a_running", timestamp_a, edge_cnt - zero_a);
      rd_ch_a = 2'd0;
      n = edge_cnt;
      cap0 = n + 48'd6 - zero_a;
      push_a(n + 48'd7, 4'b0001, 4'b0001, 4'b0000, cap0);
      start_a = 4'b0001;
      tick();
      start_a = 4'b0000;
      check("t1_busy_after_start", 48'(busy_a[0]), 48'd1);
      repeat (10) tick();

      // Periodic L=3 on ch1, shadow rewritten to L=1 between fires
      load_a(2'd1, 48'd3);
      rd_ch_a = 2'd1;
      n = edge_cnt;
      for (int i = 0; i < 9; i++)
         push_a(n + 48'(offs[i]), 4'b0010, 4'b0010, 4'b0010, n + 48'(offs[i]) - 48'd1 - zero_a);
      start_a = 4'b0010; periodic_a = 4'b0010;
      tick();
      start_a = 4'b0000; periodic_a = 4'b0000;
      while (edge_cnt < n + 48'd21) tick();
      load_a(2'd1, 48'd1);
      while (edge_cnt < n + 48'd31) tick();
      abort_a = 4'b0010;
      tick();
      abort_a = 4'b0000;
      check("t2_busy_after_abort", 48'(busy_a[1]), 48'd0);
      repeat (5) tick();

      // L=0 on ch2 with start held high in one-shot mode
      load_a(2'd2, 48'd0);
      rd_ch_a = 2'd2;
      n = edge_cnt;
      for (int i = 1; i <= 4; i++)
         push_a(n + 48'(2 * i), 4'b0100, 4'b0100, 4'b0000, n + 48'(2 * i) - 48'd1 - zero_a);
      start_a = 4'b0100;
      repeat (7) tick();
      start_a = 4'b0000;
      repeat (4) tick();

      // Abort ch0 in the cycle its count reaches zero
      load_a(2'd0, 48'd2);
      rd_ch_a = 2'd0;
      start_a = 4'b0001;
      tick();
      start_a = 4'b0000;
      tick();
      tick();
      check("t4_busy_before_abort", 48'(busy_a[0]), 48'd1);
      abort_a = 4'b0001;
      tick();
      abort_a = 4'b0000;
      check("t4_fire_after_abort", 48'(fire_a[0]), 48'd0);
      check("t4_busy_after_abort", 48'(busy_a[0]), 48'd0);
      check("t4_capture_kept", rd_fire_ts_a, cap0);
      start_a = 4'b0001; abort_a = 4'b0001;
      tick();
      start_a = 4'b0000; abort_a = 4'b0000;
      check("t4_start_abort_idle", 48'(busy_a[0]), 48'd0);
      repeat (6) tick();

      // Fire coinciding with ts_clr captures the pre-clear value
      load_a(2'd0, 48'd3);
      n = edge_cnt;
      push_a(n + 48'd5, 4'b0001, 4'b0001, 4'b0000, n + 48'd4 - zero_a);
      start_a = 4'b0001;
      tick();
      start_a = 4'b0000;
      repeat (3) tick();
      ts_clr_a = 1'b1;
      tick();
      ts_clr_a = 1'b0;
      zero_a = edge_cnt;
      check("t5_ts_cleared", timestamp_a, 48'd0);
      tick();
      check("t5_ts_after_clear", timestamp_a, 48'd1);

      // All channels started together with equal L=4
      for (int c = 0; c < 4; c++) load_a(2'(c), 48'd4);
      rd_ch_a = 2'd3;
      n = edge_cnt;
      push_a(n + 48'd6, 4'b1111, 4'b1111, 4'b0000, n + 48'd5 - zero_a);
      start_a = 4'b1111;
      tick();
      start_a = 4'b0000;
      repeat (8) tick();

      // Reset mid-run clears captures and timestamps
      rst = 1'b1;
      tick();
      rst = 1'b0;
      zero_a = edge_cnt;
      zero_b = edge_cnt;
      check("rst2_cap_a", rd_fire_ts_a, 48'd0);
      check("rst2_ts_a", timestamp_a, 48'd0);
      check("rst2_busy_a", 48'(busy_a), 48'd0);

      // Reduced build: out-of-range channel writes are dropped
      load_b(2'd0, 12'd2);
      load_b(2'd1, 12'd2);
      load_b(2'd2, 12'd2);
      wr_en_b = 1'b1; wr_ch_b = 2'd3; wr_data_b = 4'hF;
      repeat (3) tick();
      wr_en_b = 1'b0;
      rd_ch_b = 2'd2;
      n = edge_cnt;
      push_b(n + 48'd4, 3'b111, 3'b111, 3'b000, (n + 48'd3 - zero_b) & 48'hFFF);
      start_b = 3'b111;
      tick();
      start_b = 3'b000;
      repeat (6) tick();

      // Most significant word is written first: words 0,1,0 give L=16
      load_b(2'd1, 12'h010);
      rd_ch_b = 2'd1;
      n = edge_cnt;
      push_b(n + 48'd18, 3'b010, 3'b010, 3'b000, (n + 48'd17 - zero_b) & 48'hFFF);
      start_b = 3'b010;
      tick();
      start_b = 3'b000;
      repeat (20) tick();

      // Reduced timestamp wraps to zero
      while ((edge_cnt - zero_b) < 48'd4094) tick();
      check("b_ts_fffe", 48'(timestamp_b), 48'hFFE);
      tick();
      check("b_ts_ffff", 48'(timestamp_b), 48'hFFF);
      tick();
      check("b_ts_wrap", 48'(timestamp_b), 48'd0);
      tick();
      check("b_ts_after_wrap", 48'(timestamp_b), 48'd1);

      repeat (3) tick();
      check("a_queue_drained", 48'(q_a.size()), 48'd0);
      check("b_queue_drained", 48'(q_b.size()), 48'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
